// File: rtl/seq_counter_if.sv
// Bundles the control inputs and count outputs of seq_counter.
// master drives the controls and observes the count; slave is the counter.
// There is no handshake: every control is sampled on each rising clock edge.
interface seq_counter_if #(
    parameter int WIDTH = 3
);
    logic             en;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [1:0]       mode;
    logic             sat;
    logic [WIDTH-1:0] q;
    logic             tc;

    modport master (
        output en, load, load_val, mode, sat,
        input  q, tc
    );

    modport slave (
        input  en, load, load_val, mode, sat,
        output q, tc
    );
endinterface

// File: rtl/seq_counter.sv
// Multi-mode counter: binary up, binary down, gray up and Johnson ring.
// Priority is rst > load > en > hold. tc is combinational from q, mode and en,
// so it reflects the pre-load q when load and en are both high.
// Optional feature macro: SEQ_COUNTER_GRAY_EN. When it is undefined the gray
// logic is left out, mode 10 holds q (load still works) and tc stays 0.
module seq_counter #(
    parameter int WIDTH     = 3,
    parameter int MAX_COUNT = 2**WIDTH - 1
) (
    input logic          clk,
    input logic          rst,
    seq_counter_if.slave bus
);
    typedef enum logic [1:0] {
        MODE_UP      = 2'b00,
        MODE_DOWN    = 2'b01,
        MODE_GRAY    = 2'b10,
        MODE_JOHNSON = 2'b11
    } mode_e;

    localparam logic [WIDTH-1:0] MAX_Q  = WIDTH'(MAX_COUNT);
    localparam logic [WIDTH-1:0] ZERO_Q = '0;
    // Terminal pattern shared by gray and Johnson modes: MSB set, rest clear.
    localparam logic [WIDTH-1:0] TOP_Q  = {1'b1, {(WIDTH-1){1'b0}}};

    mode_e            mode;
    logic [WIDTH-1:0] q_next;
    logic             at_term;

    assign mode = mode_e'(bus.mode);

`ifdef SEQ_COUNTER_GRAY_EN
    function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
        logic [WIDTH-1:0] b;
        b[WIDTH-1] = g[WIDTH-1];
        for (int i = WIDTH - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    function automatic logic [WIDTH-1:0] bin2gray(input logic [WIDTH-1:0] b);
        return b ^ (b >> 1);
    endfunction
`endif

    // Next-state selection: load overrides counting, en=0 holds.
    always_comb begin
        q_next = bus.q;
        if (bus.load) begin
            q_next = bus.load_val;
        end else if (bus.en) begin
            case (mode)
                MODE_UP: begin
                    // Values above MAX_COUNT (only reachable by load) wrap too.
                    if (bus.q >= MAX_Q) begin
                        q_next = bus.sat ? bus.q : ZERO_Q;
                    end else begin
                        q_next = bus.q + 1'b1;
                    end
                end
                MODE_DOWN: begin
                    if (bus.q == ZERO_Q) begin
                        q_next = bus.sat ? ZERO_Q : MAX_Q;
                    end else if (bus.q > MAX_Q) begin
                        q_next = MAX_Q;
                    end else begin
                        q_next = bus.q - 1'b1;
                    end
                end
                MODE_GRAY: begin
`ifdef SEQ_COUNTER_GRAY_EN
                    q_next = bin2gray(gray2bin(bus.q) + 1'b1);
`else
                    q_next = bus.q;
`endif
                end
                MODE_JOHNSON: begin
                    // Illegal loaded patterns are shifted as-is, not corrected.
                    q_next = {bus.q[WIDTH-2:0], ~bus.q[WIDTH-1]};
                end
                default: q_next = bus.q;
            endcase
        end
    end

    // Terminal-state decode for the current mode, gated by en.
    always_comb begin
        at_term = 1'b0;
        case (mode)
            MODE_UP:      at_term = (bus.q == MAX_Q);
            MODE_DOWN:    at_term = (bus.q == ZERO_Q);
`ifdef SEQ_COUNTER_GRAY_EN
            MODE_GRAY:    at_term = (bus.q == TOP_Q);
`else
            MODE_GRAY:    at_term = 1'b0;
`endif
            MODE_JOHNSON: at_term = (bus.q == TOP_Q);
            default:      at_term = 1'b0;
        endcase
        bus.tc = bus.en & at_term;
    end

    // Count register; reset clears it immediately and holds it at zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.q <= '0;
        end else begin
            bus.q <= q_next;
        end
    end
endmodule

// File: tb/tb_seq_counter.sv
// Randomized and directed checks of seq_counter against a behavioural model.
// Built with WIDTH=3, MAX_COUNT=5; honours SEQ_COUNTER_GRAY_EN if defined.
module tb_seq_counter;
    localparam int W    = 3;
    localparam int MAXC = 5;
    localparam int MOD  = 1 << W;

    logic clk;
    logic rst;

    seq_counter_if #(.WIDTH(W)) bus ();

    seq_counter #(.WIDTH(W), .MAX_COUNT(MAXC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- scoreboard state ----------------
    int             n_tests;
    int             n_fail;
    int             model_q;
    logic [W-1:0]   exp_q[$];

    task automatic check_val(input string tag, input int obs, input int exp);
        n_tests++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d required %0d", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int gray_of(input int n);
        return (n ^ (n >> 1)) % MOD;
    endfunction

    function automatic int model_next(input int q, input bit en, input bit load,
                                      input int lv, input int mode, input bit sat);
        if (load) return lv;
        if (!en) return q;
        case (mode)
            0: begin
                if (q >= MAXC) return sat ? q : 0;
                return q + 1;
            end
            1: begin
                if (q == 0) return sat ? 0 : MAXC;
                if (q > MAXC) return MAXC;
                return q - 1;
            end
            2: begin
`ifdef SEQ_COUNTER_GRAY_EN
                // Find q's position in the gray sequence, then take the next code.
                for (int n = 0; n < MOD; n++) begin
                    if (gray_of(n) == q) return gray_of((n + 1) % MOD);
                end
                return q;
`else
                return q;
`endif
            end
            default: begin
                // Twisted ring: shift left, feed back the inverted old MSB.
                return ((q * 2) % MOD) + (((q >> (W - 1)) & 1) ^ 1);
            end
        endcase
    endfunction

    function automatic bit model_tc(input int q, input bit en, input int mode);
        if (!en) return 1'b0;
        case (mode)
            0: return q == MAXC;
            1: return q == 0;
`ifdef SEQ_COUNTER_GRAY_EN
            2: return q == (1 << (W - 1));
`else
            2: return 1'b0;
`endif
            default: return q == (1 << (W - 1));
        endcase
    endfunction

    // ---------------- driver ----------------
    // One clock: drive at negedge, check tc, predict q, check q after the edge.
    task automatic step(input bit en, input bit load, input int lv, input int mode,
                        input bit sat, output int q_obs);
        logic [W-1:0] e;
        @(negedge clk);
        bus.en       = en;
        bus.load     = load;
        bus.load_val = W'(lv);
        bus.mode     = 2'(mode);
        bus.sat      = sat;
        #1;
        check_val("tc", int'(bus.tc), int'(model_tc(model_q, en, mode)));
        exp_q.push_back(W'(model_next(model_q, en, load, lv, mode, sat)));
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check_val("q", int'(bus.q), int'(e));
        model_q = int'(e);
        q_obs   = int'(bus.q);
    endtask

    task automatic idle_inputs();
        bus.en       = 1'b0;
        bus.load     = 1'b0;
        bus.load_val = '0;
        bus.mode     = 2'b00;
        bus.sat      = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    int q_obs;
    int prev;
    int exp_026[8] = '{1, 2, 3, 4, 5, 0, 1, 2};
    int exp_027[4] = '{1, 0, 0, 0};
    int exp_029[6] = '{1, 3, 7, 6, 4, 0};
    int exp_028[8] = '{1, 3, 2, 6, 7, 5, 4, 0};

    initial begin
        n_tests = 0;
        n_fail  = 0;
        model_q = 0;
        rst     = 1'b1;
        idle_inputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_val("reset_q", int'(bus.q), 0);
        rst = 1'b0;

        // Binary up from reset with wrap at MAX_COUNT.
        for (int i = 0; i < 8; i++) begin
            step(1, 0, 0, 0, 0, q_obs);
            check_val("up_seq", q_obs, exp_026[i]);
        end

        // Binary down, saturating at zero.
        step(0, 1, 2, 1, 1, q_obs);
        check_val("down_load", q_obs, 2);
        for (int i = 0; i < 4; i++) begin
            step(1, 0, 0, 1, 1, q_obs);
            check_val("down_sat_seq", q_obs, exp_027[i]);
        end

        // Binary down wraps to MAX_COUNT and clamps out-of-range values.
        step(1, 0, 0, 1, 0, q_obs);
        check_val("down_wrap", q_obs, MAXC);
        step(0, 1, 7, 1, 0, q_obs);
        step(1, 0, 0, 1, 0, q_obs);
        check_val("down_clamp", q_obs, MAXC);

        // Up saturate holds at MAX_COUNT with tc still high.
        step(1, 0, 0, 0, 1, q_obs);
        check_val("up_sat_hold", q_obs, MAXC);

        // Johnson ring from zero.
        step(0, 1, 0, 3, 0, q_obs);
        for (int i = 0; i < 6; i++) begin
            step(1, 0, 0, 3, 0, q_obs);
            check_val("johnson_seq", q_obs, exp_029[i]);
        end

`ifdef SEQ_COUNTER_GRAY_EN
        step(0, 1, 0, 2, 0, q_obs);
        prev = 0;
        for (int i = 0; i < 8; i++) begin
            step(1, 0, 0, 2, 0, q_obs);
            check_val("gray_seq", q_obs, exp_028[i]);
            check_val("gray_onebit", $countones(W'(prev ^ q_obs)), 1);
            prev = q_obs;
        end
`else
        // Gray disabled: mode 10 holds, tc low, load honoured.
        step(0, 1, 3, 2, 0, q_obs);
        step(1, 0, 0, 2, 0, q_obs);
        check_val("gray_off_hold", q_obs, 3);
        check_val("gray_off_tc", int'(bus.tc), 0);
        step(1, 1, 5, 2, 0, q_obs);
        check_val("gray_off_load", q_obs, 5);
        prev = exp_028[0];
`endif

        // Asynchronous reset mid-count at q=4.
        step(0, 1, 3, 0, 0, q_obs);
        step(1, 0, 0, 0, 0, q_obs);
        check_val("pre_rst_q", q_obs, 4);
        @(negedge clk);
        bus.en   = 1'b1;
        bus.mode = 2'b00;
        #1;
        rst = 1'b1;
        #1;
        check_val("async_rst_q", int'(bus.q), 0);
        check_val("rst_tc_up", int'(bus.tc), 0);
        bus.mode = 2'b01;
        #1;
        check_val("rst_tc_down", int'(bus.tc), 1);
        idle_inputs();
        #1;
        rst     = 1'b0;
        model_q = 0;

        // Load wins over en; next up-step from 6 wraps to 0.
        step(1, 1, 6, 0, 0, q_obs);
        check_val("load_over_en", q_obs, 6);
        step(1, 0, 0, 0, 0, q_obs);
        check_val("up_wrap_from_6", q_obs, 0);

        // Random traffic, including mode switches mid-count.
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 3) != 0), ($urandom_range(0, 7) == 0),
                 int'($urandom_range(0, MOD - 1)), int'($urandom_range(0, 3)),
                 1'($urandom_range(0, 1)), q_obs);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
